// File: rtl/avalon_pio_gen_pkg.sv
// Shared definitions for the parametrised Avalon-MM PIO: register indices,
// edge-capture modes, bus widths and the ID word builder.
package avalon_pio_pkg;

  localparam int AVS_AW    = 3;
  localparam int AVS_DW    = 32;
  localparam int DEB_CNT_W = 16;

  typedef enum logic [AVS_AW-1:0] {
    ADDR_DATA      = 3'd0,
    ADDR_OUT       = 3'd1,
    ADDR_OUT_SET   = 3'd2,
    ADDR_OUT_CLR   = 3'd3,
    ADDR_EDGE_CAP  = 3'd4,
    ADDR_IRQ_MASK  = 3'd5,
    ADDR_EDGE_MODE = 3'd6,
    ADDR_ID        = 3'd7
  } pio_addr_e;

  localparam logic [1:0] EM_RISE = 2'd0;
  localparam logic [1:0] EM_FALL = 2'd1;
  localparam logic [1:0] EM_BOTH = 2'd2;

  // Lets software discover the bank widths of a given instance.
  function automatic logic [AVS_DW-1:0] pio_id(input int in_w, input int out_w);
    logic [7:0] iw;
    logic [7:0] ow;
    iw = 8'(in_w);
    ow = 8'(out_w);
    return {16'h0000, ow, iw};
  endfunction

endpackage

// File: rtl/avalon_pio_gen_if.sv
// Avalon-MM slave bus bundle for the PIO: word address, strobes, data.
interface avalon_pio_gen_if
  import avalon_pio_pkg::*;
  ();

  logic [AVS_AW-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [AVS_DW-1:0] avs_writedata;
  logic [AVS_DW-1:0] avs_readdata;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

endinterface

// File: rtl/avalon_pio_gen_debounce.sv
// One input bit: two-flop synchroniser followed by a counting debouncer that
// only accepts a new level after it has held for DEB_CNT consecutive cycles.
module pio_debounce
  import avalon_pio_pkg::*;
#(
  parameter int DEB_CNT = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  output logic stable_o
);

  localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEB_CNT - 1);

  logic                 sync1_q;
  logic                 sync2_q;
  logic                 stable_q;
  logic                 stable_d;
  logic [DEB_CNT_W-1:0] cnt_q;
  logic [DEB_CNT_W-1:0] cnt_d;

  // Any return to the stable level restarts the window, so short glitches vanish.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= in_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/avalon_pio_gen.sv
// Avalon-MM PIO: debounced input bank with edge capture and maskable irq,
// plus an output bank with atomic set/clear.
module avalon_pio_gen
  import avalon_pio_pkg::*;
#(
  parameter int               IN_W      = 10,
  parameter int               OUT_W     = 32,
  parameter int               DEB_CNT   = 50000,
  parameter logic [OUT_W-1:0] OUT_RESET = '0
) (
  input  logic              clk,
  input  logic              reset,
  avalon_pio_gen_if.slave   avs,
  input  logic [IN_W-1:0]   in_port,
  output logic [OUT_W-1:0]  out_port,
  output logic              irq
);

  logic [IN_W-1:0]   stable;
  logic [IN_W-1:0]   prev_q;
  logic [IN_W-1:0]   rise;
  logic [IN_W-1:0]   fall;
  logic [IN_W-1:0]   edge_new;
  logic [IN_W-1:0]   w1c;
  logic [IN_W-1:0]   edge_cap_q, edge_cap_d;
  logic [IN_W-1:0]   irq_mask_q, irq_mask_d;
  logic [1:0]        edge_mode_q, edge_mode_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              irq_q, irq_d;
  logic [AVS_DW-1:0] rdata;
  logic [AVS_DW-1:0] readdata_q, readdata_d;

  generate
    for (genvar gi = 0; gi < IN_W; gi++) begin : g_deb
      pio_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
        .clk      (clk),
        .reset    (reset),
        .in_i     (in_port[gi]),
        .stable_o (stable[gi])
      );
    end
  endgenerate

  always_comb begin
    rise = stable & ~prev_q;
    fall = ~stable & prev_q;
    case (edge_mode_q)
      EM_RISE: edge_new = rise;
      EM_FALL: edge_new = fall;
      default: edge_new = rise | fall;
    endcase
  end

  always_comb begin
    out_d       = out_q;
    irq_mask_d  = irq_mask_q;
    edge_mode_d = edge_mode_q;
    w1c         = '0;
    if (avs.avs_write) begin
      case (avs.avs_address)
        ADDR_OUT:       out_d       = avs.avs_writedata[OUT_W-1:0];
        ADDR_OUT_SET:   out_d       = out_q | avs.avs_writedata[OUT_W-1:0];
        ADDR_OUT_CLR:   out_d       = out_q & ~avs.avs_writedata[OUT_W-1:0];
        ADDR_EDGE_CAP:  w1c         = avs.avs_writedata[IN_W-1:0];
        ADDR_IRQ_MASK:  irq_mask_d  = avs.avs_writedata[IN_W-1:0];
        ADDR_EDGE_MODE: edge_mode_d = avs.avs_writedata[1:0];
        default: ;
      endcase
    end
    // A fresh edge beats a simultaneous clear so no event is ever lost.
    edge_cap_d = (edge_cap_q & ~w1c) | edge_new;
    irq_d      = |(edge_cap_q & irq_mask_q);
  end

  // Read mux sees pre-write state, so a same-cycle read returns the old value.
  always_comb begin
    rdata = '0;
    case (avs.avs_address)
      ADDR_DATA:      rdata = AVS_DW'(stable);
      ADDR_OUT:       rdata = AVS_DW'(out_q);
      ADDR_EDGE_CAP:  rdata = AVS_DW'(edge_cap_q);
      ADDR_IRQ_MASK:  rdata = AVS_DW'(irq_mask_q);
      ADDR_EDGE_MODE: rdata = AVS_DW'(edge_mode_q);
      ADDR_ID:        rdata = pio_id(IN_W, OUT_W);
      default:        rdata = '0;
    endcase
    readdata_d = avs.avs_read ? rdata : readdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q       <= OUT_RESET;
      prev_q      <= '0;
      edge_cap_q  <= '0;
      irq_mask_q  <= '0;
      edge_mode_q <= EM_RISE;
      irq_q       <= 1'b0;
      readdata_q  <= '0;
    end else begin
      out_q       <= out_d;
      prev_q      <= stable;
      edge_cap_q  <= edge_cap_d;
      irq_mask_q  <= irq_mask_d;
      edge_mode_q <= edge_mode_d;
      irq_q       <= irq_d;
      readdata_q  <= readdata_d;
    end
  end

  assign out_port         = out_q;
  assign irq              = irq_q;
  assign avs.avs_readdata = readdata_q;

endmodule

// File: tb/tb_avalon_pio_gen.sv
// Directed bench for avalon_pio_gen with IN_W=10, OUT_W=32, DEB_CNT=4,
// OUT_RESET=32'hA5; expected values are hand-derived cycle counts.
module tb_avalon_pio_gen;

  logic        clk;
  logic        reset;
  logic [9:0]  in_port;
  logic [31:0] out_port;
  logic        irq;
  logic [31:0] rd;
  int          n_checks;
  int          n_fail;

  avalon_pio_gen_if bus ();

  avalon_pio_gen #(
    .IN_W      (10),
    .OUT_W     (32),
    .DEB_CNT   (4),
    .OUT_RESET (32'h0000_00A5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .avs      (bus.slave),
    .in_port  (in_port),
    .out_port (out_port),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus tasks start and end on a falling edge; the strobe is sampled in between.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    @(negedge clk);
    bus.avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    @(negedge clk);
    bus.avs_read    = 1'b0;
    d = bus.avs_readdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks          = 0;
    n_fail            = 0;
    reset             = 1'b1;
    in_port           = '0;
    bus.avs_address   = '0;
    bus.avs_read      = 1'b0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = '0;
    repeat (3) @(negedge clk);
    check("rst_readdata", bus.avs_readdata, 32'h0);
    reset = 1'b0;

    // Reset state
    check("rst_out_port", out_port, 32'h0000_00A5);
    check("rst_irq", {31'b0, irq}, 32'h0);
    bus_read(3'd7, rd);  check("id", rd, 32'h0000_200A);
    bus_read(3'd0, rd);  check("rst_data", rd, 32'h0);
    bus_read(3'd4, rd);  check("rst_edge_cap", rd, 32'h0);

    // Rising edge on bit 0: stable at cycle 6, edge_cap at 7, irq at 8
    bus_write(3'd5, 32'h1);
    in_port[0] = 1'b1;
    repeat (5) @(negedge clk);
    bus_read(3'd0, rd);  check("data_before_c6", rd, 32'h0);
    check("irq_c6", {31'b0, irq}, 32'h0);
    bus_read(3'd0, rd);  check("data_after_c6", rd, 32'h1);
    check("irq_c7", {31'b0, irq}, 32'h0);
    bus_read(3'd4, rd);  check("edge_cap_c7", rd, 32'h1);
    check("irq_c8", {31'b0, irq}, 32'h1);
    bus_write(3'd4, 32'h1);
    check("irq_hold_after_w1c", {31'b0, irq}, 32'h1);
    @(negedge clk);
    check("irq_drop_after_w1c", {31'b0, irq}, 32'h0);

    // 3-cycle glitch on bit 3 never qualifies
    in_port[3] = 1'b1;
    repeat (3) @(negedge clk);
    in_port[3] = 1'b0;
    repeat (10) @(negedge clk);
    bus_read(3'd0, rd);  check("glitch_data", rd, 32'h1);
    bus_read(3'd4, rd);  check("glitch_edge_cap", rd, 32'h0);

    // Falling-edge mode on bit 2 with full mask
    bus_write(3'd6, 32'h1);
    bus_write(3'd5, 32'h3FF);
    in_port[2] = 1'b1;
    repeat (10) @(negedge clk);
    bus_read(3'd4, rd);  check("fall_mode_rise_ignored", rd, 32'h0);
    bus_read(3'd0, rd);  check("data_bits_0_2", rd, 32'h5);
    in_port[2] = 1'b0;
    repeat (7) @(negedge clk);
    check("fall_irq_c7", {31'b0, irq}, 32'h0);
    @(negedge clk);
    check("fall_irq_c8", {31'b0, irq}, 32'h1);
    bus_read(3'd4, rd);  check("fall_edge_cap", rd, 32'h4);
    bus_write(3'd4, 32'h4);
    check("fall_irq_hold", {31'b0, irq}, 32'h1);
    @(negedge clk);
    check("fall_irq_drop", {31'b0, irq}, 32'h0);
    bus_read(3'd4, rd);  check("fall_edge_cap_cleared", rd, 32'h0);

    // Output bank set/clear
    bus_read(3'd1, rd);  check("out_read_reset", rd, 32'hA5);
    bus_write(3'd2, 32'hF0);
    check("out_set", out_port, 32'hF5);
    bus_read(3'd2, rd);  check("out_set_reads_0", rd, 32'h0);
    bus_write(3'd3, 32'h05);
    check("out_clr", out_port, 32'hF0);
    bus_read(3'd3, rd);  check("out_clr_reads_0", rd, 32'h0);

    // Same-cycle read and write of OUT: read returns the old value
    bus.avs_address   = 3'd1;
    bus.avs_writedata = 32'h55;
    bus.avs_write     = 1'b1;
    bus.avs_read      = 1'b1;
    @(negedge clk);
    bus.avs_write     = 1'b0;
    bus.avs_read      = 1'b0;
    check("rw_read_old", bus.avs_readdata, 32'hF0);
    check("rw_write_new", out_port, 32'h55);

    // W1C on bit 1 in the same cycle a new edge lands: set wins
    bus_write(3'd6, 32'h2);
    bus_read(3'd6, rd);  check("edge_mode_rb", rd, 32'h2);
    in_port[1] = 1'b1;
    repeat (10) @(negedge clk);
    bus_read(3'd4, rd);  check("both_rise_cap", rd, 32'h2);
    in_port[1] = 1'b0;
    repeat (6) @(negedge clk);
    bus_write(3'd4, 32'h2);
    bus_read(3'd4, rd);  check("w1c_vs_set", rd, 32'h2);
    bus_write(3'd4, 32'h2);
    bus_read(3'd4, rd);  check("w1c_plain", rd, 32'h0);

    // Asynchronous reset in the middle of a debounce window
    in_port[5] = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_out", out_port, 32'hA5);
    check("async_rst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    bus_read(3'd0, rd);  check("requal_before_c6", rd, 32'h0);
    bus_read(3'd0, rd);  check("requal_after_c6", rd, 32'h21);
    bus_read(3'd4, rd);  check("requal_edge_cap", rd, 32'h21);
    bus_read(3'd5, rd);  check("requal_mask_reset", rd, 32'h0);
    check("requal_irq", {31'b0, irq}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
